// File: rtl/line_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module   : line_decoder_scan
// Purpose  : Registered N-to-2^N line decoder with a direct select mode and a
//            self-stepping scan mode that holds each line for dwell+1 cycles.
// Revision : 1.0
// ============================================================================
module line_decoder_scan #(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 4,
    localparam int c_OUT_W = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               E,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               start,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
    output logic [c_OUT_W-1:0] D,
    output logic [SEL_W-1:0]   idx,
    output logic               busy,
    output logic               wrap
);

    localparam logic [c_OUT_W-1:0] c_LINE0 = {{(c_OUT_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]   c_LAST  = {SEL_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_OUT_W-1:0]  r_d;
    logic [SEL_W-1:0]    r_idx;
    logic [DWELL_W-1:0]  r_dcnt;
    logic                r_wrap;

    logic [c_OUT_W-1:0]  w_sel_line;
    logic [c_OUT_W-1:0]  w_idx_line;
    logic [c_OUT_W-1:0]  w_next_line;

    assign w_sel_line  = E ? (c_LINE0 << sel) : '0;
    assign w_idx_line  = c_LINE0 << r_idx;
    // While a line is shown, r_d is one-hot at r_idx, so the next line is a shift.
    assign w_next_line = {r_d[c_OUT_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_d     <= '0;
            r_idx   <= '0;
            r_dcnt  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!mode) begin
                        r_d <= w_sel_line;
                    end else if (start && E) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        r_dcnt  <= dwell;
                        r_d     <= c_LINE0;
                    end else begin
                        r_d <= '0;
                    end
                end

                S_SCAN: begin
                    if (!mode) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        r_d     <= w_sel_line;
                    end else if (!E) begin
                        r_d <= '0;
                    end else if (r_d == '0) begin
                        // Returning from a pause: relight the line without
                        // consuming dwell, so the line still gets dwell+1 lit
                        // E-high cycles in total.
                        r_d <= w_idx_line;
                    end else if (r_dcnt != '0) begin
                        r_dcnt <= r_dcnt - 1'b1;
                    end else if (r_idx != c_LAST) begin
                        r_idx  <= r_idx + 1'b1;
                        r_dcnt <= dwell;
                        r_d    <= w_next_line;
                    end else begin
                        r_wrap <= 1'b1;
                        r_idx  <= '0;
                        if (loop) begin
                            r_dcnt <= dwell;
                            r_d    <= c_LINE0;
                        end else begin
                            r_state <= S_IDLE;
                            r_d     <= '0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_d     <= '0;
                end
            endcase
        end
    end

    assign D    = r_d;
    assign idx  = r_idx;
    assign busy = (r_state == S_SCAN);
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_line_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_decoder_scan
// Purpose  : Scenario tasks plus randomized traffic against a line-level model.
// Revision : 1.0
// ============================================================================
module tb_line_decoder_scan;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       E     = 1'b0;
    logic       mode  = 1'b0;
    logic [2:0] sel   = '0;
    logic       start = 1'b0;
    logic       loop  = 1'b0;
    logic [3:0] dwell = '0;
    logic [7:0] D;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;

    int n_vec = 0;
    int n_err = 0;

    line_decoder_scan #(.SEL_W(3), .DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .E     (E),
        .mode  (mode),
        .sel   (sel),
        .start (start),
        .loop  (loop),
        .dwell (dwell),
        .D     (D),
        .idx   (idx),
        .busy  (busy),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    // Line-level model: which line is active, how many E-high cycles it has
    // been served, how many it must be served, and whether it is dark.
    bit         m_scan   = 1'b0;
    bit         m_dark   = 1'b0;
    int         m_line   = 0;
    int         m_served = 0;
    int         m_hold   = 1;
    logic [7:0] m_d      = '0;
    logic       m_wrap   = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            m_scan = 1'b0; m_dark = 1'b0; m_line = 0; m_served = 0; m_hold = 1;
            m_d = '0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (!m_scan) begin
                if (!mode)
                    m_d = E ? (8'd1 << sel) : 8'd0;
                else if (start && E) begin
                    m_scan = 1'b1; m_dark = 1'b0; m_line = 0;
                    m_served = 0; m_hold = int'(dwell) + 1; m_d = 8'd1;
                end else
                    m_d = 8'd0;
            end else if (!mode) begin
                m_scan = 1'b0; m_line = 0;
                m_d = E ? (8'd1 << sel) : 8'd0;
            end else begin
                if (!E)
                    m_dark = 1'b1;
                else if (m_dark)
                    m_dark = 1'b0;
                else begin
                    m_served++;
                    if (m_served == m_hold) begin
                        m_served = 0;
                        m_hold   = int'(dwell) + 1;
                        if (m_line == 7) begin
                            m_wrap = 1'b1;
                            m_line = 0;
                            if (!loop) m_scan = 1'b0;
                        end else
                            m_line++;
                    end
                end
                m_d = (m_scan && !m_dark) ? (8'd1 << m_line) : 8'd0;
            end
        end
    end

    wire [12:0] dut_vec = {D, idx, busy, wrap};
    wire [12:0] m_vec   = {m_d, 3'(m_line), m_scan, m_wrap};

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (dut_vec !== 13'h0) begin
            n_err++;
            $display("FAIL reset_async: got D=%h idx=%0d busy=%b wrap=%b, want all zero", D, idx, busy, wrap);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (dut_vec !== 13'h0) begin
            n_err++;
            $display("FAIL reset_held: got D=%h idx=%0d busy=%b wrap=%b, want all zero", D, idx, busy, wrap);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        mode = 1'b0; E = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            @(negedge clk);
            n_vec++;
            if (D !== (8'd1 << i) || dut_vec !== m_vec) begin
                n_err++;
                $display("FAIL direct sel=%0d: got D=%h idx=%0d busy=%b wrap=%b, want D=%h idx=%0d busy=%b wrap=%b",
                         i, D, idx, busy, wrap, 8'd1 << i, m_line, m_scan, m_wrap);
            end
        end
        sel = 3'd5; E = 1'b0;
        @(negedge clk);
        n_vec++;
        if (D !== 8'h00 || dut_vec !== m_vec) begin
            n_err++;
            $display("FAIL direct_disabled: got D=%h, want D=00", D);
        end
    endtask

    task automatic test_single_scan();
        int busy_cycles = 0;
        int wraps = 0;
        mode = 1'b1; loop = 1'b0; dwell = 4'd2; E = 1'b1; start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_vec++;
            if (dut_vec !== m_vec || (c < 24 && D !== (8'd1 << (c / 3)))) begin
                n_err++;
                $display("FAIL single_scan c=%0d: got D=%h idx=%0d busy=%b wrap=%b, want D=%h idx=%0d busy=%b wrap=%b",
                         c, D, idx, busy, wrap, m_d, m_line, m_scan, m_wrap);
            end
            if (busy) busy_cycles++;
            if (wrap) begin
                wraps++;
                n_vec++;
                if (busy !== 1'b0 || D !== 8'h00) begin
                    n_err++;
                    $display("FAIL single_wrap_edge: got busy=%b D=%h, want busy=0 D=00", busy, D);
                end
            end
        end
        n_vec++;
        if (busy_cycles != 24) begin
            n_err++;
            $display("FAIL single_busy_len: got %0d cycles, want 24", busy_cycles);
        end
        n_vec++;
        if (wraps != 1) begin
            n_err++;
            $display("FAIL single_wrap_count: got %0d, want 1", wraps);
        end
    endtask

    task automatic test_loop_dwell();
        int wraps = 0;
        logic [7:0] exp_d;
        mode = 1'b1; loop = 1'b1; dwell = 4'd0; E = 1'b1; start = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_d = (c < 24) ? (8'd1 << (c % 8)) : (8'd1 << ((c - 24) / 4));
            n_vec++;
            if (dut_vec !== m_vec || D !== exp_d) begin
                n_err++;
                $display("FAIL loop_scan c=%0d: got D=%h idx=%0d busy=%b wrap=%b, want D=%h idx=%0d busy=%b wrap=%b",
                         c, D, idx, busy, wrap, exp_d, m_line, m_scan, m_wrap);
            end
            if (c < 24 && wrap) wraps++;
            if (c == 23) dwell = 4'd3;
        end
        n_vec++;
        if (wraps != 2) begin
            n_err++;
            $display("FAIL loop_wrap_count: got %0d, want 2", wraps);
        end
        mode = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dut_vec !== m_vec || busy !== 1'b0) begin
            n_err++;
            $display("FAIL loop_abort: got D=%h busy=%b, want D=%h busy=0", D, busy, m_d);
        end
    endtask

    task automatic test_pause();
        bit found = 1'b0;
        logic [7:0] exp_d;
        mode = 1'b1; loop = 1'b0; dwell = 4'd2; E = 1'b1; start = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_vec++;
            if (dut_vec !== m_vec) begin
                n_err++;
                $display("FAIL pause_run: got D=%h idx=%0d, want D=%h idx=%0d", D, idx, m_d, m_line);
            end
            if (idx == 3'd4) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL pause_timeout: idx=%0d, want 4 within 100 cycles", idx);
        end
        @(negedge clk);
        E = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== m_vec || D !== 8'h00 || idx !== 3'd4 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL pause_dark k=%0d: got D=%h idx=%0d busy=%b, want D=00 idx=4 busy=1", k, D, idx, busy);
            end
        end
        E = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_d = (k < 2) ? 8'h10 : 8'h20;
            n_vec++;
            if (dut_vec !== m_vec || D !== exp_d) begin
                n_err++;
                $display("FAIL pause_resume k=%0d: got D=%h, want D=%h", k, D, exp_d);
            end
        end
        mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        mode = 1'b1; loop = 1'b1; dwell = 4'd1; E = 1'b1; start = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (idx == 3'd2) found = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (dut_vec !== m_vec || D !== 8'h04 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_start: got D=%h busy=%b, want D=04 busy=1", D, busy);
        end
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (idx == 3'd6) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL abort_timeout: idx=%0d, want 6 within 100 cycles", idx);
        end
        mode = 1'b0; sel = 3'd2; E = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dut_vec !== m_vec || D !== 8'h04 || busy !== 1'b0 || wrap !== 1'b0 || idx !== 3'd0) begin
            n_err++;
            $display("FAIL abort: got D=%h idx=%0d busy=%b wrap=%b, want D=04 idx=0 busy=0 wrap=0", D, idx, busy, wrap);
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        mode = 1'b1; loop = 1'b1; dwell = 4'd1; E = 1'b1; start = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (idx == 3'd3) found = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (dut_vec !== 13'h0 || m_vec !== 13'h0) begin
            n_err++;
            $display("FAIL async_reset: got D=%h idx=%0d busy=%b wrap=%b, want all zero", D, idx, busy, wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== m_vec || D !== 8'h00 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset k=%0d: got D=%h busy=%b, want D=00 busy=0", k, D, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            E     = ($urandom_range(0, 7) != 0);
            mode  = ($urandom_range(0, 15) != 0);
            sel   = 3'($urandom);
            start = ($urandom_range(0, 9) == 0);
            loop  = 1'($urandom_range(0, 1));
            dwell = 4'($urandom_range(0, 3));
            @(negedge clk);
            n_vec++;
            if (dut_vec !== m_vec || $countones(D) > 1) begin
                n_err++;
                $display("FAIL random c=%0d: got D=%h idx=%0d busy=%b wrap=%b, want D=%h idx=%0d busy=%b wrap=%b",
                         c, D, idx, busy, wrap, m_d, m_line, m_scan, m_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_single_scan();
        test_loop_dwell();
        test_pause();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
